key_event_ctrl: RTL
===================

# key_event_ctrl

Debounced push-button event controller for the SoC's key inputs, presented as an Avalon-MM slave. It synchronizes and debounces up to NUM_KEYS raw active-low buttons and latches press (and optionally release) events in sticky capture registers. It raises a maskable level interrupt, so the Nios II software reads clean key events instead of polling a raw input port.

## Interface
- NUM_KEYS, 2, number of key inputs (1..32)
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles required to accept a level change (1 ms at 50 MHz); minimum 2
- CNT_W, 16, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES

- clk  in  1  system clock
- reset_n  in  1  reset, asynchronous, active-low
- chipselect  in  1  Avalon slave select
- address  in  2  register word address
- read  in  1  read strobe
- write  in  1  write strobe
- writedata  in  32  write data
- readdata  out  32  registered read data
- key_n  in  NUM_KEYS  raw asynchronous buttons, 0 = pressed
- irq  out  1  level interrupt, active-high

## Operation
- Reset is asynchronous, active-low, on reset_n. Clock is clk.
- Per key, a 2-flop synchronizer inverts key_n to active-high s[i]. Synchronizer flops reset to "not pressed".
- Per key, the debouncer holds a debounced level db[i] and counter cnt[i]:
  - s[i] == db[i]: cnt cleared to 0.
  - s[i] != db[i] and cnt < DEBOUNCE_CYCLES-1: cnt increments.
  - s[i] != db[i] and cnt == DEBOUNCE_CYCLES-1: db[i] toggles and cnt clears.
  - Any bounce back to db[i] before acceptance restarts the count from 0.
- Register map (word address; bits above NUM_KEYS read 0, writes to them are ignored):
  - 0 STATE (RO): db.
  - 1 MASK (RW): interrupt enable per key.
  - 2 PRESS_CAP (R/W1C): bit set on a db 0->1 transition. Writing 1 clears the bit.
  - 3 RELEASE_CAP (R/W1C): bit set on a db 1->0 transition. Present only with the macro; see Configuration.
- Writes take effect only when chipselect & write are both high.
- Set/clear collision on the same bit in the same cycle: set wins. The bit stays 1.
- irq is registered: irq <= |(PRESS_CAP & MASK) | |(RELEASE_CAP & MASK).
- Reset values: readdata = 0, irq = 0, MASK = 0, both capture registers = 0, db = 0, cnt = 0.
- Reset asserted mid-debounce discards all partial counts and captured events.

## Timing
- Read latency is 1 cycle. readdata is registered on every clk: mux(address) when chipselect & read, else 0. Output is zero-extended.
- Key press latency, counted with key_n stable low from before edge 0:
  - s[i] high after edge 2.
  - db[i] and PRESS_CAP[i] set at edge 2+DEBOUNCE_CYCLES.
  - irq high at edge 3+DEBOUNCE_CYCLES, if masked-in.
- After a W1C write at edge N, irq falls at edge N+1 if no other enabled capture bit is pending.
- A MASK write at edge N affects irq at edge N+1.
- Keys are independent. Simultaneous acceptances on several keys set all their bits at the same edge.

## Configuration
- KEY_EVENT_RELEASE_EN defined: RELEASE_CAP is implemented at address 3. It is W1C and participates in irq through MASK.
- KEY_EVENT_RELEASE_EN undefined: address 3 reads 0 and writes to it are ignored. No release logic is synthesized. irq depends on PRESS_CAP only.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and NUM_KEYS=2.
- Reset check: hold reset_n low, then release it with key_n=2'b11 and read addresses 0..3. Every read returns 0 and irq stays 0.
- Clean press: write MASK=1. Drive key_n[0] low before edge 0. STATE bit0=1 and PRESS_CAP=1 at edge 6, and irq=1 at edge 7.
- Bounce: pulse key_n[0] low 3 cycles, high 1 cycle, low 3 cycles. No STATE change and no capture occur. Then hold it low: acceptance comes 4 cycles after the synchronized level settles.
- W1C and collision:
  - Write PRESS_CAP=1: the bit clears and irq falls 1 cycle later.
  - Repeat the write in the same cycle key 1 is accepted: PRESS_CAP ends at 2'b10.
- Mask gating: with MASK=0, a press sets PRESS_CAP=1 and irq stays 0. Writing MASK=1 raises irq on the next edge.
- Release (macro defined): release key 0 after a press. RELEASE_CAP bit0=1 at 2+4 edges after key_n rises. Without the macro, address 3 reads 0 and irq stays low.

Source files
------------

// File: rtl/key_event_ctrl.sv
// key_event_ctrl: synchronizes and debounces active-low keys, latches press events in W1C
// registers behind an Avalon-MM slave and raises a maskable irq. KEY_EVENT_RELEASE_EN adds RELEASE_CAP.
module key_event_ctrl #(
    parameter int NUM_KEYS        = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                chipselect,
    input  logic [1:0]          address,
    input  logic                read,
    input  logic                write,
    input  logic [31:0]         writedata,
    output logic [31:0]         readdata,
    input  logic [NUM_KEYS-1:0] key_n,
    output logic                irq
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NUM_KEYS-1:0] meta_q, meta_d, sync_q, sync_d, db_q, db_d;
    logic [NUM_KEYS-1:0] mask_q, mask_d, press_q, press_d;
    logic [NUM_KEYS-1:0] acc, wr_bits, rel_pend, rd_mux;
    logic [CNT_W-1:0]    cnt_q [NUM_KEYS];
    logic [CNT_W-1:0]    cnt_d [NUM_KEYS];
    logic [31:0]         readdata_q, readdata_d;
    logic                irq_q, irq_d, wr_en;
    logic                unused_wd;

    assign wr_en     = chipselect & write;
    assign wr_bits   = writedata[NUM_KEYS-1:0];
    assign unused_wd = ^{1'b0, writedata};
    assign readdata  = readdata_q;
    assign irq       = irq_q;

    // A level is accepted on the DEBOUNCE_CYCLES-th consecutive cycle it differs from db.
    always_comb begin
        meta_d = ~key_n;
        sync_d = meta_q;
        for (int i = 0; i < NUM_KEYS; i++) begin
            acc[i]   = (sync_q[i] != db_q[i]) && (cnt_q[i] == CNT_LAST);
            cnt_d[i] = (sync_q[i] == db_q[i] || acc[i]) ? '0 : cnt_q[i] + 1'b1;
        end
        db_d = db_q ^ acc;
    end

    // Set beats a simultaneous W1C clear of the same bit.
    always_comb begin
        mask_d  = (wr_en && address == 2'd1) ? wr_bits : mask_q;
        press_d = (press_q & ~((wr_en && address == 2'd2) ? wr_bits : '0)) | (acc & ~db_q);
    end

`ifdef KEY_EVENT_RELEASE_EN
    logic [NUM_KEYS-1:0] release_q, release_d;

    always_comb begin
        release_d = (release_q & ~((wr_en && address == 2'd3) ? wr_bits : '0)) | (acc & db_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            release_q <= '0;
        end else begin
            release_q <= release_d;
        end
    end

    assign rel_pend = release_q;
`else
    assign rel_pend = '0;
`endif

    always_comb begin
        rd_mux     = address == 2'd0 ? db_q :
                     address == 2'd1 ? mask_q :
                     address == 2'd2 ? press_q : rel_pend;
        readdata_d = (chipselect && read) ? 32'(rd_mux) : '0;
        irq_d      = |((press_q | rel_pend) & mask_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q     <= '0;
            sync_q     <= '0;
            db_q       <= '0;
            mask_q     <= '0;
            press_q    <= '0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
            for (int i = 0; i < NUM_KEYS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            meta_q     <= meta_d;
            sync_q     <= sync_d;
            db_q       <= db_d;
            cnt_q      <= cnt_d;
            mask_q     <= mask_d;
            press_q    <= press_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end
endmodule
